cic_decim_mc: RTL and testbench

Multi-channel, parametrised CIC decimator for the receive DSP chain in the `dspclk` domain. It accepts CHANNELS parallel signed samples on a shared `nd` strobe and decimates them by a run-time programmable `rate`. Output gain is normalised so that the DC gain is independent of rate for power-of-two rates. It adds rate-change flush, start-up transient suppression, rounding and saturation, and is the drop-in successor for the single-channel fixed-width decimator.

---
 rtl/cic_decim_mc.sv | 202 ++++++++++++++++++++
 tb/tb_cic_decim_mc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: shared control and phase/warm-up logic, one
// cic_lane per channel carrying the integrator/comb/round/saturate datapath.
module cic_lane #(
    parameter int DIN_W  = 12,
    parameter int DOUT_W = 16,
    parameter int STAGES = 4,
    parameter int ACC_W  = 60,
    parameter int SH_W   = 6
) (
    input  logic              dspclk,
    input  logic              reset,
    input  logic              clr,
    input  logic              acc_en,
    input  logic [DIN_W-1:0]  din,
    input  logic [STAGES-1:0] cmb_en,
    input  logic              rnd_en,
    input  logic              out_en,
    input  logic [SH_W-1:0]   sh,
    output logic [DOUT_W-1:0] dout
);
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W-DOUT_W+2){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W-DOUT_W+2){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic [ACC_W-1:0]      din_ext;
    logic signed [ACC_W:0] c_ext, half, rnd_n, rnd_q;

    assign din_ext = {{(ACC_W-DIN_W){din[DIN_W-1]}}, din};

    // Integrators chain combinationally so one accepted sample moves the whole cascade.
    for (genvar i = 0; i < STAGES; i++) begin : g_int
        logic [ACC_W-1:0] acc, sum;
        if (i == 0) begin : g_first
            assign sum = acc + din_ext;
        end else begin : g_next
            assign sum = acc + g_int[i-1].sum;
        end
        always_ff @(posedge dspclk) begin
            if (clr)         acc <= '0;
            else if (acc_en) acc <= sum;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_cmb
        logic [ACC_W-1:0] cin, dly, dif;
        if (i == 0) begin : g_first
            assign cin = g_int[STAGES-1].acc;
        end else begin : g_next
            assign cin = g_cmb[i-1].dif;
        end
        always_ff @(posedge dspclk) begin
            if (clr) begin
                dly <= '0;
                dif <= '0;
            end else if (cmb_en[i]) begin
                dly <= cin;
                dif <= cin - dly;
            end
        end
    end

    assign c_ext = {g_cmb[STAGES-1].dif[ACC_W-1], g_cmb[STAGES-1].dif};
    assign half  = (sh == '0) ? '0 : ((ACC_W+1)'(1) << (sh - SH_W'(1)));
    assign rnd_n = (c_ext + half) >>> sh;

    always_ff @(posedge dspclk) begin
        if (clr)         rnd_q <= '0;
        else if (rnd_en) rnd_q <= rnd_n;
    end

    // sclr leaves dout holding the last delivered result.
    always_ff @(posedge dspclk) begin
        if (reset)
            dout <= '0;
        else if (out_en) begin
            if (rnd_q > SAT_HI)      dout <= SAT_HI[DOUT_W-1:0];
            else if (rnd_q < SAT_LO) dout <= SAT_LO[DOUT_W-1:0];
            else                     dout <= rnd_q[DOUT_W-1:0];
        end
    end
endmodule

module cic_decim_mc #(
    parameter int CHANNELS     = 2,
    parameter int DIN_W        = 12,
    parameter int DOUT_W       = 16,
    parameter int STAGES       = 4,
    parameter int RATE_W       = 13,
    parameter int MAX_RATE     = 4096,
    parameter int DEFAULT_RATE = 4
) (
    input  logic                       dspclk,
    input  logic                       reset,
    input  logic                       sclr,
    input  logic                       rate_we,
    input  logic [RATE_W-1:0]          rate,
    input  logic                       nd,
    input  logic [CHANNELS*DIN_W-1:0]  din,
    output logic                       rfd,
    output logic                       rdy,
    output logic [CHANNELS*DOUT_W-1:0] dout
);
    localparam int LG_MAX = $clog2(MAX_RATE);
    localparam int ACC_W  = DIN_W + STAGES*LG_MAX;
    localparam int SH_W   = $clog2(STAGES*LG_MAX + 1);
    localparam int WC_W   = $clog2(STAGES + 1);

    typedef enum logic [1:0] {ST_RESET, ST_FLUSH, ST_WARMUP, ST_RUN} state_t;

    function automatic int clog2_rate(input logic [RATE_W-1:0] v);
        int r;
        r = LG_MAX;
        for (int k = LG_MAX; k >= 0; k--)
            if ((32'd1 << k) >= 32'(v)) r = k;
        return r;
    endfunction

    state_t                          state_q, state_d;
    logic [RATE_W-1:0]               rate_q, rate_src, rate_cl, phase_q;
    logic [SH_W-1:0]                 sh_q, sh_n;
    logic [WC_W-1:0]                 warm_q;
    logic                            clr, accept, last, strobe, keep, out_fire;
    logic [STAGES+1:0]               vld_pipe, keep_pipe;
    logic [CHANNELS-1:0][DIN_W-1:0]  din_lane;
    logic [CHANNELS-1:0][DOUT_W-1:0] dout_lane;

    assign clr      = reset | sclr | rate_we;
    assign accept   = nd & rfd;
    assign last     = (phase_q == rate_q - RATE_W'(1));
    assign strobe   = accept & last;
    assign keep     = strobe & (state_q == ST_RUN);
    assign out_fire = vld_pipe[STAGES+1] & keep_pipe[STAGES+1] & ~clr;

    assign rate_src = reset ? RATE_W'(DEFAULT_RATE) : rate;
    assign rate_cl  = (rate_src < RATE_W'(2))        ? RATE_W'(2) :
                      (rate_src > RATE_W'(MAX_RATE)) ? RATE_W'(MAX_RATE) : rate_src;
    assign sh_n     = SH_W'(STAGES*clog2_rate(rate_cl) - (DOUT_W - DIN_W));

    always_ff @(posedge dspclk) begin
        if (reset || rate_we) begin
            rate_q <= rate_cl;
            sh_q   <= sh_n;
        end
    end

    always_ff @(posedge dspclk) begin
        if (reset) state_q <= ST_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rfd     = 1'b0;
        case (state_q)
            ST_RESET, ST_FLUSH: state_d = ST_WARMUP;
            ST_WARMUP: begin
                rfd = ~clr;
                if (strobe && warm_q == WC_W'(STAGES-1)) state_d = ST_RUN;
            end
            default: rfd = ~clr;
        endcase
        if (sclr || rate_we) state_d = ST_FLUSH;
    end

    always_ff @(posedge dspclk) begin
        if (clr) begin
            phase_q   <= '0;
            warm_q    <= '0;
            vld_pipe  <= '0;
            keep_pipe <= '0;
            rdy       <= 1'b0;
        end else begin
            if (accept)
                phase_q <= last ? '0 : phase_q + RATE_W'(1);
            if (strobe && warm_q != WC_W'(STAGES))
                warm_q <= warm_q + WC_W'(1);
            // Strobe walks the pipe: comb stage i on bit i, then round, then output.
            vld_pipe  <= {vld_pipe[STAGES:0], strobe};
            keep_pipe <= {keep_pipe[STAGES:0], keep};
            rdy       <= out_fire;
        end
    end

    assign din_lane = din;
    assign dout     = dout_lane;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        cic_lane #(
            .DIN_W(DIN_W), .DOUT_W(DOUT_W), .STAGES(STAGES), .ACC_W(ACC_W), .SH_W(SH_W)
        ) u_lane (
            .dspclk (dspclk),
            .reset  (reset),
            .clr    (clr),
            .acc_en (accept),
            .din    (din_lane[c]),
            .cmb_en (vld_pipe[STAGES-1:0]),
            .rnd_en (vld_pipe[STAGES]),
            .out_en (out_fire),
            .sh     (sh_q),
            .dout   (dout_lane[c])
        );
    end
endmodule

// File: tb/tb_cic_decim_mc.sv
// Randomised scoreboard bench for cic_decim_mc; the reference treats the CIC
// as an FIR of STAGES cascaded length-R boxcars, decimated by R from a zero state.
module tb_cic_decim_mc;
    localparam int CH = 2, DIN_W = 12, DOUT_W = 16, N = 4, RATE_W = 13, MAXR = 4096, DEFR = 4;

    logic                   dspclk = 1'b0, reset = 1'b1, sclr = 1'b0, rate_we = 1'b0, nd = 1'b0;
    logic [RATE_W-1:0]      rate = '0;
    logic [CH*DIN_W-1:0]    din = '0;
    logic                   rfd, rdy;
    logic [CH*DOUT_W-1:0]   dout;

    cic_decim_mc #(
        .CHANNELS(CH), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .STAGES(N),
        .RATE_W(RATE_W), .MAX_RATE(MAXR), .DEFAULT_RATE(DEFR)
    ) dut (
        .dspclk(dspclk), .reset(reset), .sclr(sclr), .rate_we(rate_we), .rate(rate),
        .nd(nd), .din(din), .rfd(rfd), .rdy(rdy), .dout(dout)
    );

    always #5 dspclk = ~dspclk;

    typedef struct {
        logic [CH*DOUT_W-1:0] d;
        int                   due;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   e;
    longint h[$];
    int     xs[CH][$];
    int     rate_m, warm_m, phase_m, cyc = 0, n_chk = 0, n_pass = 0;
    bit     flush_m, mon_en = 0;
    int     rlist[7];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
    endtask

    // Impulse response of N cascaded boxcars of length r, built by running sums.
    task automatic build_h(input int r);
        longint a[$], b[$];
        longint acc;
        a = {1};
        for (int s = 0; s < N; s++) begin
            b = {};
            acc = 0;
            for (int m = 0; m < a.size() + r - 1; m++) begin
                if (m < a.size()) acc += a[m];
                if (m - r >= 0 && m - r < a.size()) acc -= a[m-r];
                b.push_back(acc);
            end
            a = b;
        end
        h = a;
    endtask

    task automatic latch_rate(input int v);
        rate_m = (v < 2) ? 2 : (v > MAXR) ? MAXR : v;
        build_h(rate_m);
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) xs[c].delete();
        exp_q.delete();
        phase_m = 0;
        warm_m  = 0;
        flush_m = 1;
    endtask

    function automatic logic [CH*DOUT_W-1:0] model_out();
        logic [CH*DOUT_W-1:0] d;
        logic [DOUT_W-1:0]    t;
        longint               y;
        int                   lg, s, n;
        d  = '0;
        lg = 0;
        while ((1 << lg) < rate_m) lg++;
        s = N*lg - (DOUT_W - DIN_W);
        for (int c = 0; c < CH; c++) begin
            n = xs[c].size() - 1;
            y = 0;
            for (int m = 0; m < h.size() && m <= n; m++) y += h[m] * longint'(xs[c][n-m]);
            if (s > 0) y = (y + (longint'(1) <<< (s - 1))) >>> s;
            if (y > 32767)  y = 32767;
            if (y < -32768) y = -32768;
            t = y[DOUT_W-1:0];
            d[c*DOUT_W +: DOUT_W] = t;
        end
        return d;
    endfunction

    task automatic step(input bit i_nd, input bit i_sclr, input bit i_rwe, input int i_rate,
                        input logic [DIN_W-1:0] d0, input logic [DIN_W-1:0] d1);
        bit   rfd_e;
        exp_t x;
        @(negedge dspclk);
        reset = 1'b0; nd = i_nd; sclr = i_sclr; rate_we = i_rwe;
        rate = RATE_W'(i_rate); din = {d1, d0};
        rfd_e = !(i_sclr || i_rwe) && !flush_m;
        #1 chk("rfd", rfd, rfd_e);
        if (i_sclr || i_rwe) begin
            if (i_rwe) latch_rate(i_rate);
            model_clear();
        end else begin
            flush_m = 0;
            if (i_nd && rfd_e) begin
                xs[0].push_back($signed(d0));
                xs[1].push_back($signed(d1));
                if (phase_m == rate_m - 1) begin
                    phase_m = 0;
                    if (warm_m == N) begin
                        x.d   = model_out();
                        x.due = cyc + N + 3;
                        exp_q.push_back(x);
                    end else warm_m++;
                end else phase_m++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge dspclk);
        reset = 1'b1; nd = 1'b0; sclr = 1'b0; rate_we = 1'b0;
        latch_rate(DEFR);
        model_clear();
        #1 chk("rfd_in_reset", rfd, 0);
        @(negedge dspclk);
        #1;
        chk("rdy_reset", rdy, 0);
        chk("dout_reset", dout, 0);
        chk("rfd_in_reset", rfd, 0);
        mon_en = 1;
    endtask

    always @(posedge dspclk) begin
        cyc++;
        #1;
        if (mon_en && !reset) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rdy", rdy, 1);
                chk("dout", dout, e.d);
            end else chk("rdy_idle", rdy, 0);
        end
    end

    initial begin
        int r, wait_n;
        rlist = '{2, 3, 4, 6, 7, 8, 16};
        repeat (2) @(negedge dspclk);
        do_reset();

        // Default rate, DC 0x010, nd every 4th cycle.
        for (int i = 0; i < 200; i++) step(i % 4 == 0, 0, 0, 0, 12'h010, 12'h010);
        // Rate 8; nd coincident with rate_we is dropped.
        step(1, 0, 1, 8, 12'h010, 12'h010);
        for (int i = 0; i < 400; i++) step(i % 4 == 0, 0, 0, 0, 12'h010, 12'h010);
        // Rate 5, non-power-of-two rounding.
        step(0, 0, 1, 5, 0, 0);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 12'h010, 12'h010);
        // Rate clamping at the low end with random data.
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 100; i++) step($urandom_range(0, 1), 0, 0, 0, 12'($urandom), 12'($urandom));
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 100; i++) step($urandom_range(0, 1), 0, 0, 0, 12'($urandom), 12'($urandom));
        // Full-scale channels at rate 4.
        step(0, 0, 1, 4, 0, 0);
        for (int i = 0; i < 80; i++) step(1, 0, 0, 0, 12'h7FF, 12'h800);

        // sclr mid-period, then 2 cycles after a completing nd.
        for (int i = 0; i < 42; i++) step(1, 0, 0, 0, 12'($urandom), 12'($urandom));
        step(0, 1, 0, 0, 0, 0);
        wait_n = 0;
        while (exp_q.size() == 0 && wait_n < 100) begin
            step(1, 0, 0, 0, 12'($urandom), 12'($urandom));
            wait_n++;
        end
        chk("sclr_setup_timeout", wait_n < 100, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 12'($urandom), 12'($urandom));
        // sclr together with rate_we latches and clears.
        step(1, 1, 1, 3, 0, 0);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 12'($urandom), 12'($urandom));
        // nd every cycle at rate 2.
        step(1, 0, 1, 2, 12'h123, 12'h456);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 12'($urandom), 12'($urandom));

        // Random episodes with occasional sclr.
        for (int ep = 0; ep < 6; ep++) begin
            r = rlist[$urandom_range(0, 6)];
            step(0, 0, 1, r, 0, 0);
            for (int i = 0; i < 300; i++)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, 0, 0,
                     12'($urandom), 12'($urandom));
        end

        // Reset with a result in flight, then default rate again.
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 12'($urandom), 12'($urandom));
        do_reset();
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 12'h010, 12'h010);

        // Oversized rate clamps to MAX_RATE.
        step(0, 0, 1, 5000, 0, 0);
        for (int i = 0; i < 20500; i++) step(1, 0, 0, 0, 12'h010, 12'h010);

        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
